// File: rtl/mux_sel_sequencer_pkg.sv
// Shared definitions for the mux select sequencer.
//   - mode_e     : operating modes carried on the 2-bit mode input
//   - NUM_CH     : number of mux channels being sequenced
//   - nxt_t      : result of the next-channel search (channel plus wrap flag)
//   - next_chan(): priority search for the next enabled channel after sel
package mux_sel_sequencer_pkg;

    localparam int NUM_CH = 4;

    typedef enum logic [1:0] {
        MODE_AUTO   = 2'b00,
        MODE_MANUAL = 2'b01,
        MODE_STEP   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    typedef struct packed {
        logic       wrap;
        logic [1:0] chan;
    } nxt_t;

    // Looks at sel+1, sel+2, sel+3, sel+4 (mod 4) and returns the first
    // enabled index. The loop runs from the farthest candidate down to the
    // nearest so the nearest hit is the one left standing. sel+4 is sel
    // itself, so a lone enabled current channel is found and counts as a wrap.
    // With mask==0 the result is meaningless; callers must not advance then.
    function automatic nxt_t next_chan(input logic [1:0] sel, input logic [3:0] mask);
        nxt_t       r;
        logic [1:0] idx;
        r.chan = sel;
        r.wrap = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            idx = sel + 2'(k);
            if (mask[idx]) begin
                r.chan = idx;
            end
        end
        r.wrap = (r.chan <= sel);
        return r;
    endfunction

endpackage

// File: rtl/mux_sel_sequencer_if.sv
// Bundle of the sequencer's control inputs and mux-facing outputs.
//   mode[1:0], man_sel[1:0], step_btn, mask[3:0]  : controls toward the sequencer
//   s1, s2, an_n[3:0], tick, frame_done            : outputs from the sequencer
// master = the side that drives the controls, slave = the sequencer itself.
interface mux_sel_sequencer_if;
    logic [1:0] mode;
    logic [1:0] man_sel;
    logic       step_btn;
    logic [3:0] mask;
    logic       s1;
    logic       s2;
    logic [3:0] an_n;
    logic       tick;
    logic       frame_done;

    modport master (
        output mode, man_sel, step_btn, mask,
        input  s1, s2, an_n, tick, frame_done
    );

    modport slave (
        input  mode, man_sel, step_btn, mask,
        output s1, s2, an_n, tick, frame_done
    );
endinterface

// File: rtl/mux_sel_sequencer_sync_rise.sv
// sync_rise: two-flop synchroniser for an asynchronous input followed by a
// rising-edge detector. Reusable for any button-like input.
//   clk   : system clock
//   reset : asynchronous active-high reset, clears all flops
//   d     : asynchronous input
//   pulse : one-cycle high when the synchronised input goes 0->1
// pulse is combinational from the second sync flop, so it appears two edges
// after d rises and acts on the third.
module sync_rise (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic pulse
);
    logic [1:0] sync_reg;
    logic       prev_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= 2'b00;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], d};
            prev_reg <= sync_reg[1];
        end
    end

    assign pulse = sync_reg[1] & ~prev_reg;
endmodule

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: generates the s1/s2 selects for a 4:1 mux stage.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : slave side of mux_sel_sequencer_if
//           mode     00 AUTO scan, 01 MANUAL, 10 STEP on button, 11 HOLD
//           man_sel  select used in MANUAL, {s1,s2}
//           step_btn asynchronous button, rising edge steps in STEP mode
//           mask     channel enables for scan/step, also gates an_n
//           s1/s2    registered select
//           an_n     active-low one-hot of the select, gated by mask
//           tick     one-cycle pulse per prescaler period
//           frame_done one-cycle pulse when an advance wraps around
// The prescaler free-runs in every mode; the step synchroniser also runs in
// every mode so a button already held on entry to STEP does not step.
module mux_sel_sequencer
    import mux_sel_sequencer_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input logic                 clk,
    input logic                 reset,
    mux_sel_sequencer_if.slave  bus
);
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       sel_reg, sel_next;
    logic             tick_reg;
    logic             frame_done_reg, frame_done_next;
    logic             adv_t;
    logic             step_p;
    mode_e            mode_w;
    nxt_t             nxt_w;

    assign mode_w = mode_e'(bus.mode);
    assign adv_t  = (cnt_reg == CNT_W'(TICK_DIV - 1));
    assign cnt_next = adv_t ? '0 : cnt_reg + 1'b1;
    assign nxt_w  = next_chan(sel_reg, bus.mask);

    sync_rise u_step_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.step_btn),
        .pulse (step_p)
    );

    // Only one advance source is honoured per mode, so adv_t and step_p
    // can never both move sel in the same cycle.
    always_comb begin
        sel_next        = sel_reg;
        frame_done_next = 1'b0;
        unique case (mode_w)
            MODE_AUTO: begin
                if (adv_t && (bus.mask != 4'b0000)) begin
                    sel_next        = nxt_w.chan;
                    frame_done_next = nxt_w.wrap;
                end
            end
            MODE_MANUAL: begin
                sel_next = bus.man_sel;
            end
            MODE_STEP: begin
                if (step_p && (bus.mask != 4'b0000)) begin
                    sel_next        = nxt_w.chan;
                    frame_done_next = nxt_w.wrap;
                end
            end
            MODE_HOLD: begin
                sel_next = sel_reg;
            end
            default: begin
                sel_next = sel_reg;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg        <= '0;
            sel_reg        <= 2'b00;
            tick_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            cnt_reg        <= cnt_next;
            sel_reg        <= sel_next;
            tick_reg       <= adv_t;
            frame_done_reg <= frame_done_next;
        end
    end

    assign bus.s1         = sel_reg[1];
    assign bus.s2         = sel_reg[0];
    assign bus.tick       = tick_reg;
    assign bus.frame_done = frame_done_reg;

    // an_n is combinational so masking the current channel blanks it at once.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_an
        assign bus.an_n[gi] = ~((sel_reg == 2'(gi)) & bus.mask[gi]);
    end
endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed bench for mux_sel_sequencer with TICK_DIV=4. Inputs change and
// outputs are sampled on the falling clock edge; expected values are hand
// derived from edge counts noted beside each step.
module tb_mux_sel_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   ticks;

    mux_sel_sequencer_if bus ();

    mux_sel_sequencer #(
        .TICK_DIV (4),
        .CNT_W    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
        $display("check %-16s observed=%b expected=%b", tag, obs, exp);
    endtask

    function automatic logic [3:0] sel4();
        return {2'b00, bus.s1, bus.s2};
    endfunction

    initial begin
        reset        = 1'b1;
        bus.mode     = 2'b00;
        bus.man_sel  = 2'b00;
        bus.step_btn = 1'b0;
        bus.mask     = 4'b1111;

        // reset state
        step(1);
        check("rst_sel", sel4(), 4'b0000);
        check("rst_tick", {3'b000, bus.tick}, 4'b0000);
        check("rst_fd", {3'b000, bus.frame_done}, 4'b0000);
        check("rst_an", bus.an_n, 4'b1110);
        reset = 1'b0;

        // AUTO, mask 1111: advances on edges 4, 8, 12, 16
        step(3);
        check("a_pre_tick", {3'b000, bus.tick}, 4'b0000);
        check("a_pre_sel", sel4(), 4'b0000);
        step(1);
        check("a1_sel", sel4(), 4'b0001);
        check("a1_tick", {3'b000, bus.tick}, 4'b0001);
        check("a1_an", bus.an_n, 4'b1101);
        check("a1_fd", {3'b000, bus.frame_done}, 4'b0000);
        step(4);
        check("a2_sel", sel4(), 4'b0010);
        check("a2_an", bus.an_n, 4'b1011);
        step(4);
        check("a3_sel", sel4(), 4'b0011);
        check("a3_an", bus.an_n, 4'b0111);
        check("a3_fd", {3'b000, bus.frame_done}, 4'b0000);
        step(4);
        check("a4_sel", sel4(), 4'b0000);
        check("a4_fd", {3'b000, bus.frame_done}, 4'b0001);
        check("a4_an", bus.an_n, 4'b1110);
        step(1);
        check("a5_fd", {3'b000, bus.frame_done}, 4'b0000);
        check("a5_tick", {3'b000, bus.tick}, 4'b0000);

        // AUTO, mask 1010 (after edge 17; advances at 20, 24, 28, 32)
        bus.mask = 4'b1010;
        step(3);
        check("m_sel01", sel4(), 4'b0001);
        check("m_fd0", {3'b000, bus.frame_done}, 4'b0000);
        step(4);
        check("m_sel11", sel4(), 4'b0011);
        step(4);
        check("m_wrap_sel", sel4(), 4'b0001);
        check("m_wrap_fd", {3'b000, bus.frame_done}, 4'b0001);
        step(4);
        check("m_sel11b", sel4(), 4'b0011);

        // mask 0000 freezes sel
        bus.mask = 4'b0000;
        #1;
        check("z_an", bus.an_n, 4'b1111);
        step(4);
        check("z_sel", sel4(), 4'b0011);
        check("z_fd", {3'b000, bus.frame_done}, 4'b0000);
        check("z_tick", {3'b000, bus.tick}, 4'b0001);

        // mask 0100: lone channel 2, every advance wraps
        bus.mask = 4'b0100;
        step(4);
        check("o_sel", sel4(), 4'b0010);
        check("o_fd1", {3'b000, bus.frame_done}, 4'b0001);
        step(4);
        check("o_sel2", sel4(), 4'b0010);
        check("o_fd2", {3'b000, bus.frame_done}, 4'b0001);

        // MANUAL (after edge 44)
        bus.mode    = 2'b01;
        bus.mask    = 4'b1111;
        bus.man_sel = 2'b00;
        step(1);
        check("man_sel00", sel4(), 4'b0000);
        bus.man_sel = 2'b10;
        step(1);
        check("man_sel10", sel4(), 4'b0010);
        check("man_an", bus.an_n, 4'b1011);
        bus.mask = 4'b1011;
        #1;
        check("man_mask_an", bus.an_n, 4'b1111);
        step(1);
        check("man_hold_sel", sel4(), 4'b0010);
        step(1);
        check("man_tick", {3'b000, bus.tick}, 4'b0001);
        check("man_fd", {3'b000, bus.frame_done}, 4'b0000);
        check("man_sel_tk", sel4(), 4'b0010);

        // STEP from sel 01 (after edge 49): button rises, acts on 3rd edge
        bus.man_sel = 2'b01;
        bus.mask    = 4'b1111;
        step(1);
        check("st_pre", sel4(), 4'b0001);
        bus.mode     = 2'b10;
        bus.step_btn = 1'b1;
        step(2);
        check("st_e2", sel4(), 4'b0001);
        step(1);
        check("st_e3", sel4(), 4'b0010);
        check("st_fd", {3'b000, bus.frame_done}, 4'b0000);
        step(2);
        bus.step_btn = 1'b0;
        check("st_once", sel4(), 4'b0010);
        step(4);
        check("st_no_adv", sel4(), 4'b0010);

        // entering STEP with the button already held gives no step
        bus.mode     = 2'b11;
        bus.step_btn = 1'b1;
        step(4);
        bus.mode = 2'b10;
        step(4);
        check("st_held", sel4(), 4'b0010);
        bus.step_btn = 1'b0;
        step(3);

        // HOLD at sel 10 for 20 cycles (edges 70..89, ticks at 72..88)
        bus.mode = 2'b11;
        ticks    = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (bus.tick) ticks++;
        end
        check("hold_sel", sel4(), 4'b0010);
        check("hold_ticks", 4'(ticks), 4'd5);
        bus.mode = 2'b00;
        step(2);
        check("ret_pre", sel4(), 4'b0010);
        step(1);
        check("ret_sel", sel4(), 4'b0011);
        check("ret_tick", {3'b000, bus.tick}, 4'b0001);

        // asynchronous reset mid-scan at sel 11, cnt 2, mask[0]=0
        step(2);
        bus.mask = 4'b1110;
        reset    = 1'b1;
        #1;
        check("ar_sel", sel4(), 4'b0000);
        check("ar_tick", {3'b000, bus.tick}, 4'b0000);
        check("ar_fd", {3'b000, bus.frame_done}, 4'b0000);
        check("ar_an", bus.an_n, 4'b1111);
        step(1);
        reset    = 1'b0;
        bus.mask = 4'b1111;
        step(3);
        check("ar_no_tick", {3'b000, bus.tick}, 4'b0000);
        step(1);
        check("ar_tick4", {3'b000, bus.tick}, 4'b0001);
        check("ar_sel01", sel4(), 4'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
